// File: rtl/multiplier_pipe_stall.sv
// rtl/multiplier_pipe_stall.sv - stallable pipelined WIDTHxWIDTH shift-and-add multiplier with tag
// Define MULT_SIGNED_EN for a two's-complement build; default build is unsigned.
module multiplier_pipe_stall #(
  parameter int WIDTH  = 48,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int R  = (WIDTH + STAGES - 1) / STAGES;

  logic [WIDTH-1:0] a_q    [0:STAGES-1];
  logic [WIDTH-1:0] b_q    [0:STAGES-1];
  logic [TAG_W-1:0] tag_q  [0:STAGES];
  logic [PW-1:0]    psum_q [0:STAGES];
  logic [PW-1:0]    psum_d [0:STAGES];
  logic [STAGES:0]  v_q;
  logic             adv;

  function automatic logic [PW-1:0] ext_a(input logic [WIDTH-1:0] x);
`ifdef MULT_SIGNED_EN
    return {{WIDTH{x[WIDTH-1]}}, x};
`else
    return {{WIDTH{1'b0}}, x};
`endif
  endfunction

  assign adv       = !v_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];
  assign y         = psum_q[STAGES];
  assign out_tag   = tag_q[STAGES];

  // Stage k adds rows (k-1)*R .. k*R-1 using the operands held in stage k-1.
  always_comb begin
    for (int k = 0; k <= STAGES; k++) psum_d[k] = '0;
    for (int k = 1; k <= STAGES; k++) begin
      psum_d[k] = psum_q[k-1];
      for (int i = 0; i < WIDTH; i++) begin
        if ((i / R) == (k - 1) && b_q[k-1][i]) begin
`ifdef MULT_SIGNED_EN
          if (i == WIDTH - 1) psum_d[k] = psum_d[k] - (ext_a(a_q[k-1]) << i);
          else                psum_d[k] = psum_d[k] + (ext_a(a_q[k-1]) << i);
`else
          psum_d[k] = psum_d[k] + (ext_a(a_q[k-1]) << i);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        tag_q[k]  <= '0;
        psum_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (adv) begin
      v_q       <= {v_q[STAGES-1:0], in_valid};
      a_q[0]    <= a;
      b_q[0]    <= b;
      tag_q[0]  <= in_tag;
      psum_q[0] <= psum_d[0];
      for (int k = 1; k <= STAGES; k++) begin
        tag_q[k]  <= tag_q[k-1];
        psum_q[k] <= psum_d[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

endmodule
